// File: rtl/tlb_op_unit.sv
// CP0 TLB instruction sequencer: runs TLBP/TLBR/TLBWI/TLBWR against the TLB
// management port and owns the CP0 Random register.

package tlb_op_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;
endpackage

module tlb_op_unit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int ENTRY_W = $bits(tlb_op_pkg::tlb_entry_t)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [1:0]         op_code,
    input  logic [31:0]        op_index,
    input  logic [31:0]        op_entry_hi,
    input  logic [ENTRY_W-1:0] op_entry,
    input  logic [IDX_W-1:0]   wired,
    input  logic               wired_we,
    output logic [IDX_W-1:0]   random,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [1:0]         resp_op,
    output logic [31:0]        resp_index,
    output logic [ENTRY_W-1:0] resp_entry,
    output logic [IDX_W-1:0]   tlbrw_index,
    output logic               tlbrw_we,
    output logic [ENTRY_W-1:0] tlbrw_wdata,
    input  logic [ENTRY_W-1:0] tlbrw_rdata,
    output logic [31:0]        tlbp_entry_hi,
    input  logic [31:0]        tlbp_index
);

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;
    localparam logic [1:0] OP_TLBWR = 2'd3;
    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [1:0]         code_r;
    logic [IDX_W-1:0]   idx_r;
    logic [31:0]        hi_r;
    logic [ENTRY_W-1:0] entry_r;
    logic               we_r;
    logic               resp_valid_r;
    logic [1:0]         resp_op_r;
    logic [31:0]        resp_index_r;
    logic [ENTRY_W-1:0] resp_entry_r;
    logic [IDX_W-1:0]   random_r;
    logic [IDX_W-1:0]   random_nxt_s;
    logic [IDX_W-1:0]   idx_sel_s;
    logic               op_index_unused_s;

    // Only the low IDX_W bits of CP0 Index address the TLB.
    assign op_index_unused_s = ^op_index[31:IDX_W];

    // The write strobe is suppressed combinationally so a reset cycle never writes.
    assign op_ready      = (state_r == ST_IDLE) && !rst;
    assign tlbrw_we      = we_r && !rst;
    assign tlbrw_index   = idx_r;
    assign tlbrw_wdata   = entry_r;
    assign tlbp_entry_hi = hi_r;
    assign random        = random_r;
    assign resp_valid    = resp_valid_r;
    assign resp_op       = resp_op_r;
    assign resp_index    = resp_index_r;
    assign resp_entry    = resp_entry_r;

    // Index to latch at accept: TLBWR takes the live Random value.
    always_comb begin
        idx_sel_s = op_index[IDX_W-1:0];
        case (op_code)
            OP_TLBWR: idx_sel_s = random_r;
            default:  idx_sel_s = op_index[IDX_W-1:0];
        endcase
    end

    // Random decrements toward Wired and reloads to the top entry.
    always_comb begin
        random_nxt_s = RAND_TOP;
        if (wired_we) begin
            random_nxt_s = RAND_TOP;
        end else if (random_r <= wired) begin
            random_nxt_s = RAND_TOP;
        end else begin
            random_nxt_s = random_r - {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    // Random register.
    always_ff @(posedge clk) begin
        if (rst) begin
            random_r <= RAND_TOP;
        end else begin
            random_r <= random_nxt_s;
        end
    end

    // Op sequencer: IDLE -> EXEC (one cycle at the TLB) -> RESP until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            code_r       <= 2'd0;
            idx_r        <= {IDX_W{1'b0}};
            hi_r         <= 32'd0;
            entry_r      <= {ENTRY_W{1'b0}};
            we_r         <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_op_r    <= 2'd0;
            resp_index_r <= 32'd0;
            resp_entry_r <= {ENTRY_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op_valid) begin
                        code_r  <= op_code;
                        idx_r   <= idx_sel_s;
                        hi_r    <= op_entry_hi;
                        entry_r <= op_entry;
                        we_r    <= (op_code == OP_TLBWI) || (op_code == OP_TLBWR);
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    we_r         <= 1'b0;
                    resp_valid_r <= 1'b1;
                    resp_op_r    <= code_r;
                    resp_index_r <= (code_r == OP_TLBP) ? tlbp_index : 32'd0;
                    resp_entry_r <= (code_r == OP_TLBR) ? tlbrw_rdata : {ENTRY_W{1'b0}};
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    we_r         <= 1'b0;
                    resp_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit with a small behavioural TLB on the management port.

module tb_tlb_op_unit;
    import tlb_op_pkg::*;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int ENTRY_W = $bits(tlb_entry_t);
    localparam logic [31:0] MATCH_HI = 32'hABCD_E000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               op_valid = 1'b0;
    logic               op_ready;
    logic [1:0]         op_code = 2'd0;
    logic [31:0]        op_index = 32'd0;
    logic [31:0]        op_entry_hi = 32'd0;
    logic [ENTRY_W-1:0] op_entry = {ENTRY_W{1'b0}};
    logic [IDX_W-1:0]   wired = 4'd0;
    logic               wired_we = 1'b0;
    logic [IDX_W-1:0]   random;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic [1:0]         resp_op;
    logic [31:0]        resp_index;
    logic [ENTRY_W-1:0] resp_entry;
    logic [IDX_W-1:0]   tlbrw_index;
    logic               tlbrw_we;
    logic [ENTRY_W-1:0] tlbrw_wdata;
    logic [ENTRY_W-1:0] tlbrw_rdata;
    logic [31:0]        tlbp_entry_hi;
    logic [31:0]        tlbp_index;

    logic [ENTRY_W-1:0] mem [ENTRIES];
    int                 we_count = 0;
    int                 checks = 0;
    int                 failures = 0;
    tlb_entry_t         e_s;
    tlb_entry_t         f_s;
    logic [ENTRY_W-1:0] e_val;
    logic [ENTRY_W-1:0] f_val;
    logic [ENTRY_W-1:0] w_val;

    tlb_op_unit #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_index(op_index), .op_entry_hi(op_entry_hi), .op_entry(op_entry),
        .wired(wired), .wired_we(wired_we), .random(random),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
        .resp_index(resp_index), .resp_entry(resp_entry),
        .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
        .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index)
    );

    always #5 clk = ~clk;

    // Behavioural TLB: async read, write on clock, probe hits only MATCH_HI at entry 5.
    assign tlbrw_rdata = mem[tlbrw_index];
    assign tlbp_index  = (tlbp_entry_hi == MATCH_HI) ? 32'h0000_0005 : 32'h8000_0000;

    always @(posedge clk) begin
        if (tlbrw_we) begin
            mem[tlbrw_index] <= tlbrw_wdata;
            we_count <= we_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL rst_op_ready got=%0b exp=0", op_ready); end
        checks++; if (random !== 4'd15) begin failures++; $display("FAIL rst_random got=%0d exp=15", random); end
        checks++; if (resp_valid !== 1'b0 || resp_op !== 2'd0 || resp_index !== 32'd0 || resp_entry !== {ENTRY_W{1'b0}}) begin
            failures++; $display("FAIL rst_resp got valid=%0b op=%0d idx=%h", resp_valid, resp_op, resp_index); end
        checks++; if (tlbrw_we !== 1'b0 || tlbrw_index !== 4'd0 || tlbp_entry_hi !== 32'd0) begin
            failures++; $display("FAIL rst_tlb got we=%0b idx=%0d hi=%h", tlbrw_we, tlbrw_index, tlbp_entry_hi); end
        rst = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL post_rst_op_ready got=%0b exp=1", op_ready); end
    endtask

    task automatic test_random_wrap();
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checks++; if (random !== 4'(15 - i)) begin failures++; $display("FAIL rand_down step=%0d got=%0d exp=%0d", i, random, 15 - i); end
        end
        @(negedge clk);
        checks++; if (random !== 4'd15) begin failures++; $display("FAIL rand_reload got=%0d exp=15", random); end
    endtask

    task automatic test_random_wired();
        wired = 4'd4; wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        checks++; if (random !== 4'd15) begin failures++; $display("FAIL wired_we_reload got=%0d exp=15", random); end
        for (int v = 14; v >= 4; v--) begin
            @(negedge clk);
            checks++; if (random !== 4'(v)) begin failures++; $display("FAIL wired_down got=%0d exp=%0d", random, v); end
        end
        @(negedge clk);
        checks++; if (random !== 4'd15) begin failures++; $display("FAIL wired_reload got=%0d exp=15", random); end
        repeat (6) @(negedge clk);
        checks++; if (random !== 4'd9) begin failures++; $display("FAIL wired_pre9 got=%0d exp=9", random); end
        wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        checks++; if (random !== 4'd15) begin failures++; $display("FAIL wired_we_at9 got=%0d exp=15", random); end
        wired = 4'd0;
    endtask

    task automatic test_tlbwi();
        int wc0;
        @(negedge clk);
        wc0 = we_count;
        op_valid = 1'b1; op_code = 2'd2; op_index = 32'hFFFF_FF05; op_entry = e_val;
        @(negedge clk);
        op_valid = 1'b0;
        checks++; if (tlbrw_we !== 1'b1 || tlbrw_index !== 4'd5 || tlbrw_wdata !== e_val) begin
            failures++; $display("FAIL wi_exec got we=%0b idx=%0d exp we=1 idx=5", tlbrw_we, tlbrw_index); end
        checks++; if (resp_valid !== 1'b0 || op_ready !== 1'b0) begin
            failures++; $display("FAIL wi_exec_hs got rv=%0b rdy=%0b exp 0 0", resp_valid, op_ready); end
        @(negedge clk);
        checks++; if (tlbrw_we !== 1'b0 || we_count !== wc0 + 1) begin
            failures++; $display("FAIL wi_one_write got we=%0b writes=%0d exp we=0 writes=%0d", tlbrw_we, we_count - wc0, 1); end
        checks++; if (resp_valid !== 1'b1 || resp_op !== 2'd2 || resp_index !== 32'd0 || resp_entry !== {ENTRY_W{1'b0}}) begin
            failures++; $display("FAIL wi_resp got rv=%0b op=%0d idx=%h exp 1 2 0", resp_valid, resp_op, resp_index); end
        checks++; if (mem[5] !== e_val) begin failures++; $display("FAIL wi_mem got=%h exp=%h", mem[5], e_val); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || op_ready !== 1'b1) begin
            failures++; $display("FAIL wi_done got rv=%0b rdy=%0b exp 0 1", resp_valid, op_ready); end
    endtask

    task automatic test_back_to_back();
        op_valid = 1'b1; op_code = 2'd1; op_index = 32'd5;
        @(negedge clk);
        op_valid = 1'b0;
        checks++; if (tlbrw_index !== 4'd5 || tlbrw_we !== 1'b0) begin
            failures++; $display("FAIL r_exec got idx=%0d we=%0b exp 5 0", tlbrw_index, tlbrw_we); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_op !== 2'd1 || resp_entry !== e_val || resp_index !== 32'd0) begin
            failures++; $display("FAIL r_resp got rv=%0b op=%0d entry=%h exp entry=%h", resp_valid, resp_op, resp_entry, e_val); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1 || resp_entry !== e_val || resp_op !== 2'd1 || op_ready !== 1'b0) begin
                failures++; $display("FAIL r_hold cyc=%0d got rv=%0b rdy=%0b entry=%h", i, resp_valid, op_ready, resp_entry); end
        end
        // Next op presented during the response handshake must wait one cycle.
        resp_ready = 1'b1;
        op_valid = 1'b1; op_code = 2'd0; op_entry_hi = MATCH_HI;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || op_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_gap got rv=%0b rdy=%0b exp 0 1", resp_valid, op_ready); end
        @(negedge clk);
        op_valid = 1'b0;
        checks++; if (tlbp_entry_hi !== MATCH_HI || op_ready !== 1'b0) begin
            failures++; $display("FAIL p_exec got hi=%h rdy=%0b exp %h 0", tlbp_entry_hi, op_ready, MATCH_HI); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_op !== 2'd0 || resp_index !== 32'h0000_0005 || resp_entry !== {ENTRY_W{1'b0}}) begin
            failures++; $display("FAIL p_hit got rv=%0b op=%0d idx=%h exp 1 0 00000005", resp_valid, resp_op, resp_index); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_tlbp_miss();
        op_valid = 1'b1; op_code = 2'd0; op_entry_hi = 32'h1234_5000;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_index[31] !== 1'b1) begin
            failures++; $display("FAIL p_miss got rv=%0b idx=%h exp P=1", resp_valid, resp_index); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_tlbwr();
        wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (random !== 4'd7) begin failures++; $display("FAIL wr_pre got=%0d exp=7", random); end
        op_valid = 1'b1; op_code = 2'd3; op_index = 32'd2; op_entry = f_val;
        @(negedge clk);
        op_valid = 1'b0;
        checks++; if (tlbrw_we !== 1'b1 || tlbrw_index !== 4'd7 || tlbrw_wdata !== f_val || random !== 4'd6) begin
            failures++; $display("FAIL wr_exec got we=%0b idx=%0d rand=%0d exp 1 7 6", tlbrw_we, tlbrw_index, random); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_op !== 2'd3 || mem[7] !== f_val) begin
            failures++; $display("FAIL wr_resp got rv=%0b op=%0d exp 1 3", resp_valid, resp_op); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int wc0;
        wc0 = we_count;
        op_valid = 1'b1; op_code = 2'd2; op_index = 32'd3; op_entry = w_val;
        @(negedge clk);
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (tlbrw_we !== 1'b0) begin failures++; $display("FAIL rst_exec_we got=%0b exp=0", tlbrw_we); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || we_count !== wc0 || mem[3] !== {ENTRY_W{1'b0}} || random !== 4'd15) begin
            failures++; $display("FAIL rst_abandon got rv=%0b writes=%0d rand=%0d exp 0 0 15", resp_valid, we_count - wc0, random); end
        rst = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL rst_idle got rdy=%0b exp=1", op_ready); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || tlbrw_we !== 1'b0) begin
            failures++; $display("FAIL rst_quiet got rv=%0b we=%0b exp 0 0", resp_valid, tlbrw_we); end
    endtask

    initial begin
        for (int i = 0; i < ENTRIES; i++) mem[i] = {ENTRY_W{1'b0}};
        e_s = '{vpn2: 19'h5_ABCD, asid: 8'h3C, g: 1'b0, pfn0: 20'hDEAD1, c0: 3'd3, d0: 1'b1, v0: 1'b1,
                pfn1: 20'hBEEF2, c1: 3'd2, d1: 1'b0, v1: 1'b1};
        f_s = '{vpn2: 19'h1_2345, asid: 8'hA5, g: 1'b1, pfn0: 20'h0F0F0, c0: 3'd5, d0: 1'b0, v0: 1'b1,
                pfn1: 20'h11111, c1: 3'd7, d1: 1'b1, v1: 1'b0};
        e_val = e_s;
        f_val = f_s;
        w_val = ~e_val;
        test_reset();
        test_random_wrap();
        test_random_wired();
        test_tlbwi();
        test_back_to_back();
        test_tlbp_miss();
        test_tlbwr();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlb_op_unit.md
Name: tlb_op_unit

Overview:
- Sequencer that executes the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR against the TLB's management port.
- Accepts one op from the commit stage over a valid/ready handshake, drives the TLB's tlbrw_* and tlbp_* ports, and returns results to CP0 over a valid/ready handshake.
- Owns the CP0 Random register, including the Wired-relative wrap.
- Sits between the CP0/commit logic and the TLB array; it is the initiator side of the TLB's management interface.

Parameters:
- ENTRIES, 16, number of TLB entries; must be a power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width.
- ENTRY_W, $bits(tlb_entry_t), width of one packed TLB entry.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  op request valid.
- op_ready  out  1  unit idle, can accept an op.
- op_code  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
- op_index  in  32  CP0 Index value; only bits [IDX_W-1:0] are used.
- op_entry_hi  in  32  CP0 EntryHi (VPN2/ASID) for TLBP.
- op_entry  in  ENTRY_W  entry assembled by CP0 for TLBWI/TLBWR.
- wired  in  IDX_W  CP0 Wired value.
- wired_we  in  1  CP0 Wired is being written this cycle.
- random  out  IDX_W  CP0 Random value.
- resp_valid  out  1  result valid.
- resp_ready  in  1  CP0 accepts the result.
- resp_op  out  2  op_code of the completed op.
- resp_index  out  32  TLBP result (P bit31 plus index); zero for other ops.
- resp_entry  out  ENTRY_W  TLBR read data; zero for other ops.
- tlbrw_index  out  IDX_W  to TLB.
- tlbrw_we  out  1  to TLB.
- tlbrw_wdata  out  ENTRY_W  to TLB.
- tlbrw_rdata  in  ENTRY_W  from TLB, combinational on tlbrw_index.
- tlbp_entry_hi  out  32  to TLB probe.
- tlbp_index  in  32  from TLB probe; bit31 is miss.

Behaviour:
- States: IDLE, EXEC, RESP.
- op_ready = (state==IDLE). Handshake fires on op_valid && op_ready.
- Accept (cycle T):
  - Latch op_code, op_entry_hi, op_entry.
  - Latch the index: op_index[IDX_W-1:0] for TLBR/TLBWI; the current random value for TLBWR; don't-care for TLBP.
  - Go to EXEC.
- EXEC (T+1), exactly one cycle:
  - tlbrw_index and tlbp_entry_hi are driven from the latched registers throughout, so the TLB inputs are registered.
  - TLBWI/TLBWR: tlbrw_we=1 and tlbrw_wdata=latched entry, for this cycle only.
  - TLBR: capture tlbrw_rdata into resp_entry.
  - TLBP: capture tlbp_index into resp_index.
  - Go to RESP.
- RESP (from T+2): resp_valid=1; resp_* held stable until resp_ready. On resp_ready go to IDLE. The next op can be accepted in the cycle after the resp handshake, never in the same cycle.
- tlbrw_we=0 in every state other than EXEC of a write op. tlbrw_wdata=latched entry when we=1, else don't-care.
- Random counter:
  - Reset value ENTRIES-1.
  - Each cycle: if wired_we, next=ENTRIES-1; else if random<=wired, next=ENTRIES-1; else next=random-1.
  - It keeps counting during ops. TLBWR uses the value sampled at accept.
  - If wired>=ENTRIES-1, random stays at ENTRIES-1.
- Reset values: state IDLE; op_ready=1 after reset deasserts (0 while rst=1); resp_valid=0; resp_op=0; resp_index=0; resp_entry=0; tlbrw_we=0; tlbrw_index=0; tlbp_entry_hi=0; random=ENTRIES-1.
- Reset mid-operation: an op in EXEC is abandoned with no write issued in the reset cycle; a pending response is dropped.
- No widths are truncated silently except op_index: the upper 32-IDX_W bits are ignored.

Test Plan:
- Reset, then 5 idle cycles with wired=0 -> random sequence 15,14,13,12,11. Continue -> after 0 it reloads 15.
- wired=4 -> random counts down to 4, then reloads 15. wired_we pulse when random=9 -> random=15 next cycle.
- TLBWI, op_index=0xFFFF_FF05, op_entry=E -> tlbrw_we high for exactly one cycle (T+1) with index 5 and wdata E; resp_valid at T+2 with resp_op=2 and resp_index=0.
- TLBR index 5 after the write -> resp_entry=E at T+2. With resp_ready held low 3 cycles, resp stays valid and stable and op_ready stays 0.
- TLBP with a matching entry_hi -> resp_index=0x0000_0005. With a non-matching entry_hi -> resp_index bit31=1.
- TLBWR accepted when random=7 -> write to index 7 even though random has changed by EXEC. Assert rst during EXEC of a second TLBWI -> no tlbrw_we, state IDLE, resp_valid=0.
